ts_packet_arbiter: RTL and testbench
====================================

// Module: ts_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter/mux sharing one 8-bit parallel TS output between N parallel TS sources.
//  Each source requests when it holds a complete packet. The arbiter grants one source, forwards exactly PKT_LEN
//  bytes, regenerates sync on byte 0, then re-arbitrates. Sits between per-stream packet buffers and the TS output port.
// PARAMETERS
//  N_SRC    4    number of requesting TS sources (2..16)
//  PKT_LEN  188  bytes per TS packet (204 for RS-coded streams); byte counter width = clog2(PKT_LEN)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst        in   1       asynchronous, active-high reset
//  in_data    in   8*N_SRC source i byte on [8*i+7:8*i]
//  in_valid   in   N_SRC   source i byte valid; sampled only while gnt[i]=1
//  in_sync    in   N_SRC   source i packet-start flag (checked, not forwarded)
//  req        in   N_SRC   source i holds >=1 complete packet
//  gnt        out  N_SRC   one-hot grant, registered
//  out_data   out  8       forwarded byte, registered
//  out_valid  out  1       out_data valid
//  out_sync   out  1       1 on byte 0 of every output packet
//  busy       out  1       1 while a packet transfer (or null packet) is in progress
//  sync_err   out  1       sticky: a packet's byte 0 lacked in_sync=1 or data!=8'h47
// BEHAVIOUR
//  Reset: gnt=0, out_data=0, out_valid=0, out_sync=0, busy=0, sync_err=0, rr pointer=0, byte count=0, state IDLE.
//  FSM IDLE -> XFER (-> NULL with macro):
//   IDLE: if |req, pick first set req[k] searching from ptr (ptr = last winner+1 mod N_SRC, 0 after reset).
//         Set gnt[k] next cycle, ptr<=k+1, cnt<=0, go XFER. Decision in cycle t; gnt high from t+1.
//   XFER: each cycle with in_valid[k]=1: out_data<=in_data[k], out_valid<=1, out_sync<=(cnt==0), cnt++.
//         in_valid[k]=0 (stall): out_valid<=0, cnt holds; no timeout.
//         Byte with cnt==PKT_LEN-1 accepted in cycle c: gnt=0 and state IDLE from c+1; earliest next gnt at c+2.
//  Latency: byte accepted at cycle c appears on out_* at c+1. Max throughput 1 byte/cycle within a packet.
//  Grant held for the whole packet even if req[k] drops; req/in_valid of non-granted sources ignored.
//  sync_err: set when byte with cnt==0 has in_sync[k]=0 or in_data!=8'h47. Byte is still forwarded with out_sync=1.
//   Cleared only by rst.
//  Simultaneous requests: strict rotation from ptr; a persistent requester cannot starve others
//   (worst-case wait N_SRC-1 packets).
//  Reset mid-packet: transfer truncated, all outputs at reset values next edge; no resumption.
//  busy=1 in XFER/NULL; out_valid never 1 in IDLE.
// CONFIGURATION
//  TS_NULL_INSERT_EN defined: IDLE with req==0 enters NULL and emits one null packet at 1 byte/cycle:
//   47 1F FF 10 then PKT_LEN-4 x FF, out_sync on first byte. Not preemptable; arbitration resumes in the cycle
//   after its last byte (same timing as XFER). gnt stays 0 during NULL.
//  Undefined: no NULL state; out_valid=0 whenever no packet is being forwarded.
// STRUCTURE
//  Shared header ts_interfaces.vh: TS_SYNC_BYTE=8'h47, TS_PKT_LEN_188/204, null-packet header bytes, FSM state encodings.
//  Sub-module ts_rr_arbiter (N_SRC, combinational: req, ptr -> one-hot pick, valid) instantiated once.
//  FSM, counter and output regs stay in top.
// TESTING
//  1 src0 req, 188 contiguous bytes starting 47 -> gnt[0] 1 cycle after req; out bytes 1-cycle delayed;
//    out_sync only on first; gnt low after byte 187.
//  2 req=4'b1111 held, 8 packets -> grant order 0,1,2,3,0,1,2,3; ptr wraps; no gap beyond 1 idle cycle between packets.
//  3 src2 toggles in_valid every other cycle -> out_valid mirrors with 1-cycle delay; exactly 188 valid out bytes.
//  4 src1 first byte 8'hB8 -> sync_err=1, stays 1 for later good packets until rst.
//  5 assert rst at byte 90 of a packet -> next edge all outputs 0, ptr=0; after release req[3] alone -> gnt[3].
//  6 TS_NULL_INSERT_EN, req=0 -> continuous 47 1F FF 10 FF.. packets;
//    req[1] mid-null -> gnt[1] only after null byte 187.

Source files
------------

// File: rtl/ts_packet_arbiter_pkg.sv
// Shared constants, FSM state encoding and null-packet byte lookup for the TS packet arbiter.
// Null-packet constants are used only when TS_NULL_INSERT_EN is defined.
package ts_packet_arbiter_pkg;

  localparam logic [7:0]  TsSyncByte  = 8'h47;
  localparam int unsigned TsPktLen188 = 188;
  localparam int unsigned TsPktLen204 = 204;

  // Null packet: PID 0x1FFF, payload-only adaptation field control, filled with 0xFF.
  localparam logic [7:0] TsNullHdr1 = 8'h1F;
  localparam logic [7:0] TsNullHdr2 = 8'hFF;
  localparam logic [7:0] TsNullHdr3 = 8'h10;
  localparam logic [7:0] TsNullFill = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StNull = 2'd2
  } state_e;

  function automatic logic [7:0] null_byte(input int unsigned idx);
    case (idx)
      0:       return TsSyncByte;
      1:       return TsNullHdr1;
      2:       return TsNullHdr2;
      3:       return TsNullHdr3;
      default: return TsNullFill;
    endcase
  endfunction

endpackage

// File: rtl/ts_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N_SRC.
module ts_rr_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned PtrW  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_SRC-1:0] pick_o,
  output logic [PtrW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned cand;
    logic [PtrW-1:0] cidx;
    logic found;
    cand    = 0;
    cidx    = '0;
    found   = 1'b0;
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      cand = (32'(ptr_i) + off) % N_SRC;
      cidx = PtrW'(cand);
      if (!found && req_i[cidx]) begin
        found        = 1'b1;
        pick_o[cidx] = 1'b1;
        idx_o        = cidx;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-granular round-robin mux of N_SRC parallel TS sources onto one 8-bit TS output.
// Define TS_NULL_INSERT_EN to emit null packets whenever no source is requesting.
module ts_packet_arbiter
  import ts_packet_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned PKT_LEN = TsPktLen188
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] in_data,
  input  logic [N_SRC-1:0]   in_valid,
  input  logic [N_SRC-1:0]   in_sync,
  input  logic [N_SRC-1:0]   req,
  output logic [N_SRC-1:0]   gnt,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               out_sync,
  output logic               busy,
  output logic               sync_err
);

  localparam int unsigned PtrW = $clog2(N_SRC);
  localparam int unsigned CntW = $clog2(PKT_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(PKT_LEN - 1);
  localparam logic [PtrW-1:0] LastSrc = PtrW'(N_SRC - 1);

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  gnt_q, gnt_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sync_q, out_sync_d;
  logic              sync_err_q, sync_err_d;

  logic [N_SRC-1:0]  pick;
  logic [PtrW-1:0]   pick_idx;
  logic              pick_valid;

  logic [7:0]        src_data [N_SRC];
  logic [7:0]        cur_data;
  logic              cur_valid;
  logic              cur_sync;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src_data
    assign src_data[i] = in_data[8*i +: 8];
  end

  assign cur_data  = src_data[sel_q];
  assign cur_valid = in_valid[sel_q];
  assign cur_sync  = in_sync[sel_q];

  ts_rr_arbiter #(
    .N_SRC (N_SRC),
    .PtrW  (PtrW)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sync_d  = 1'b0;
    sync_err_d  = sync_err_q;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick;
          sel_d   = pick_idx;
          ptr_d   = (pick_idx == LastSrc) ? '0 : pick_idx + PtrW'(1);
          cnt_d   = '0;
          state_d = StXfer;
        end
`ifdef TS_NULL_INSERT_EN
        else begin
          cnt_d   = '0;
          state_d = StNull;
        end
`endif
      end

      StXfer: begin
        // A stalled source simply holds the count; there is deliberately no timeout.
        if (cur_valid) begin
          out_data_d  = cur_data;
          out_valid_d = 1'b1;
          out_sync_d  = (cnt_q == '0);
          if ((cnt_q == '0) && (!cur_sync || (cur_data != TsSyncByte))) begin
            sync_err_d = 1'b1;
          end
          if (cnt_q == LastCnt) begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

`ifdef TS_NULL_INSERT_EN
      StNull: begin
        out_data_d  = null_byte(32'(cnt_q));
        out_valid_d = 1'b1;
        out_sync_d  = (cnt_q == '0);
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign busy      = (state_q != StIdle);
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Scoreboard bench for ts_packet_arbiter: drivers queue expected bytes/grants, a monitor checks them.
module tb_ts_packet_arbiter;

  localparam int unsigned NSrc   = 4;
  localparam int unsigned PktLen = 188;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [8*NSrc-1:0] in_data  = '0;
  logic [NSrc-1:0]   in_valid = '0;
  logic [NSrc-1:0]   in_sync  = '0;
  logic [NSrc-1:0]   req      = '0;
  logic [NSrc-1:0]   gnt;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_sync;
  logic              busy;
  logic              sync_err;

  typedef struct packed {
    logic [7:0] data;
    logic       sync;
  } out_t;

  out_t            exp_q[$];
  logic [NSrc-1:0] gnt_exp_q[$];
  out_t            mon_e;
  logic [NSrc-1:0] mon_g;
  logic [NSrc-1:0] gnt_prev = '0;
  int              n_checks = 0;
  int              n_pass   = 0;

  ts_packet_arbiter #(
    .N_SRC   (NSrc),
    .PKT_LEN (PktLen)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .req       (req),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sync  (out_sync),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [7:0] pkt_byte(input int s, input int i);
    return 8'((s * 40 + i * 3 + 1) & 255);
  endfunction

  function automatic logic [7:0] null_ref(input int i);
    if (i == 0) return 8'h47;
    if (i == 1) return 8'h1F;
    if (i == 3) return 8'h10;
    return 8'hFF;
  endfunction

  // Monitor: compares every presented output byte and every new grant against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: got byte 0x%0h sync %0b, expected no output",
                   out_data, out_sync);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.data));
          check("out_sync", 32'(out_sync), 32'(mon_e.sync));
        end
      end
      if ((gnt != '0) && (gnt_prev == '0)) begin
        if (gnt_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL gnt_unexpected: got gnt=%b, expected none", gnt);
        end else begin
          mon_g = gnt_exp_q.pop_front();
          check("gnt_order", 32'(gnt), 32'(mon_g));
        end
      end
    end
    gnt_prev <= rst ? '0 : gnt;
  end

  task automatic wait_gnt(input int s, output bit ok);
    logic [1:0] si;
    si = 2'(s);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt[si]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL gnt_timeout: got gnt=%b, expected gnt[%0d]=1", gnt, s);
    end
  endtask

  task automatic send_pkt(input int s, input logic [7:0] first, input bit toggle,
                          input bit drop, input int nbytes);
    bit         ok;
    bit         stall;
    int         i;
    logic [7:0] b;
    logic [1:0] si;
    si = 2'(s);
    wait_gnt(s, ok);
    if (drop) req = '0;
    if (!ok) return;
    stall = 1'b0;
    i = 0;
    while (i < nbytes) begin
      if (toggle && stall) begin
        in_valid[si] = 1'b0;
        in_sync[si]  = 1'b0;
        @(negedge clk);
        check("mirror_stall", 32'(out_valid), 0);
        stall = 1'b0;
      end else begin
        b = (i == 0) ? first : pkt_byte(s, i);
        exp_q.push_back('{data: b, sync: (i == 0)});
        in_data[{si, 3'b000} +: 8] = b;
        in_sync[si]  = (i == 0);
        in_valid[si] = 1'b1;
        @(negedge clk);
        if (toggle) check("mirror_valid", 32'(out_valid), 1);
        stall = 1'b1;
        i++;
      end
    end
    in_valid[si] = 1'b0;
    in_sync[si]  = 1'b0;
    if (nbytes == PktLen) begin
      check("gnt_release", 32'(gnt), 0);
      check("busy_release", 32'(busy), 0);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    in_valid = '0;
    in_sync  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sync", 32'(out_sync), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sync_err", 32'(sync_err), 0);

`ifdef TS_NULL_INSERT_EN
    // Idle output is filled with null packets; a mid-null request waits for the null to end.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < PktLen; i++) exp_q.push_back('{data: null_ref(i), sync: (i == 0)});
    rst = 1'b0;
    repeat (PktLen + 90) @(negedge clk);
    check("null_busy", 32'(busy), 1);
    check("null_gnt_low", 32'(gnt), 0);
    gnt_exp_q.push_back(4'b0010);
    req = 4'b0010;
    send_pkt(1, 8'h47, 1'b0, 1'b1, PktLen);
    for (int i = 0; i < PktLen; i++) exp_q.push_back('{data: null_ref(i), sync: (i == 0)});
    wait_drain();
    #1 rst = 1'b1;
    @(negedge clk);
`else
    rst = 1'b0;
    @(negedge clk);

    // 1: single source, contiguous packet, grant one cycle after request.
    req = 4'b0001;
    gnt_exp_q.push_back(4'b0001);
    @(negedge clk);
    check("t1_gnt_latency", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 1);
    req = '0;
    send_pkt(0, 8'h47, 1'b0, 1'b0, PktLen);
    wait_drain();

    // 2: all four request continuously; strict rotation with a single idle cycle between packets.
    do_reset();
    req = 4'b1111;
    for (int p = 0; p < 8; p++) gnt_exp_q.push_back(4'(1 << (p % 4)));
    for (int p = 0; p < 8; p++) begin
      send_pkt(p % 4, 8'h47, 1'b0, (p == 7), PktLen);
      if (p < 7) begin
        @(negedge clk);
        check("t2_gap", 32'(gnt), 32'(1 << ((p + 1) % 4)));
      end
    end
    wait_drain();

    // 3: source 2 alternates valid/stall; output valid follows one cycle later.
    req = 4'b0100;
    gnt_exp_q.push_back(4'b0100);
    send_pkt(2, 8'h47, 1'b1, 1'b1, PktLen);
    wait_drain();

    // 4: bad first byte sets a sticky error that survives a later good packet.
    check("t4_err_before", 32'(sync_err), 0);
    req = 4'b0010;
    gnt_exp_q.push_back(4'b0010);
    send_pkt(1, 8'hB8, 1'b0, 1'b1, PktLen);
    check("t4_err_set", 32'(sync_err), 1);
    req = 4'b0010;
    gnt_exp_q.push_back(4'b0010);
    send_pkt(1, 8'h47, 1'b0, 1'b1, PktLen);
    check("t4_err_sticky", 32'(sync_err), 1);
    wait_drain();

    // 5: reset during byte 90 truncates the packet and returns the pointer to 0.
    req = 4'b0001;
    gnt_exp_q.push_back(4'b0001);
    send_pkt(0, 8'h47, 1'b0, 1'b1, 90);
    #1;
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1;
    check("t5_gnt", 32'(gnt), 0);
    check("t5_out_data", 32'(out_data), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_sync", 32'(out_sync), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_sync_err", 32'(sync_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 4'b1001;
    gnt_exp_q.push_back(4'b0001);
    send_pkt(0, 8'h47, 1'b0, 1'b1, PktLen);
    req = 4'b1000;
    gnt_exp_q.push_back(4'b1000);
    send_pkt(3, 8'h47, 1'b0, 1'b1, PktLen);
    wait_drain();
`endif

    check("gnt_drain", 32'(gnt_exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
